// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in / serial-out reader.
// Holds the FSM state encoding, the counter-width helper and the bit-order selector.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam bit MSB_FIRST = 1'b1;

  // Width of a counter that has to hold values 0 .. w-1, for w >= 2.
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One bit of the serializer shift register.
// The bit either captures its parallel input or takes its lower neighbour.
module shift_stage (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic din_bit,
  input  logic lower_bit,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= load ? din_bit : lower_bit;
    end
  end

endmodule

// File: rtl/piso_shift_reader.sv
// Captures a WIDTH-bit word in parallel and streams it out MSB first.
// The serial side uses a valid/ready handshake; done pulses once per completed word.
module piso_shift_reader
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             ld_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             done
);

  localparam int CW      = cnt_width(WIDTH);
  localparam int OUT_BIT = MSB_FIRST ? WIDTH - 1 : 0;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             load_acc;
  logic             shift_acc;
  logic             stage_en;

  assign load_acc  = (state == IDLE) && load;
  assign shift_acc = (state == SHIFT) && sout_ready && (cnt != '0);
  assign stage_en  = load_acc || shift_acc;

  // The last bit is not shifted out: the word simply stops being presented.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic lower;
    if (i == 0) begin : g_bottom
      assign lower = 1'b0;
    end else begin : g_inner
      assign lower = shreg[i-1];
    end

    shift_stage u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (stage_en),
      .load      (load_acc),
      .din_bit   (din[i]),
      .lower_bit (lower),
      .q         (shreg[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            cnt   <= CW'(WIDTH - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (sout_ready) begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // shreg keeps the final word contents in IDLE, so sout is gated by state.
  assign ld_ready   = (state == IDLE);
  assign sout_valid = (state == SHIFT);
  assign sout       = (state == SHIFT) && shreg[OUT_BIT];

endmodule

// File: tb/tb_piso_shift_reader.sv
// Directed bench for piso_shift_reader with WIDTH=8.
// Each step drives inputs just after a rising edge and checks outputs 1 ns after the next one.
module tb_piso_shift_reader;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] din;
  logic       ld_ready;
  logic       sout;
  logic       sout_valid;
  logic       sout_ready;
  logic       done;

  int checks;
  int errors;

  piso_shift_reader #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (din),
    .ld_ready   (ld_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .sout_ready (sout_ready),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Eight bit cycles with the consumer always ready.
  task automatic check_bits(input string tag, input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      chk({tag, "_valid"}, {7'd0, sout_valid}, 8'd1);
      chk({tag, "_sout"}, {7'd0, sout}, {7'd0, w[i]});
      chk({tag, "_ldrdy"}, {7'd0, ld_ready}, 8'd0);
      tick();
    end
  endtask

  task automatic check_done_cycle(input string tag);
    chk({tag, "_done"}, {7'd0, done}, 8'd1);
    chk({tag, "_done_ldrdy"}, {7'd0, ld_ready}, 8'd1);
    chk({tag, "_done_valid"}, {7'd0, sout_valid}, 8'd0);
    chk({tag, "_done_sout"}, {7'd0, sout}, 8'd0);
  endtask

  initial begin
    logic [7:0] got;
    int         idx;
    logic       sr;

    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    load       = 1'($urandom_range(0, 1));
    din        = 8'($urandom);
    sout_ready = 1'($urandom_range(0, 1));

    // 1. Reset with random side inputs
    tick();
    chk("rst_valid", {7'd0, sout_valid}, 8'd0);
    chk("rst_ldrdy", {7'd0, ld_ready}, 8'd1);
    chk("rst_sout", {7'd0, sout}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    load = 1'b1;
    din  = 8'hFF;
    tick();
    chk("rst_load_ignored", {7'd0, sout_valid}, 8'd0);
    rst        = 1'b0;
    load       = 1'b0;
    sout_ready = 1'b1;
    tick();
    chk("idle_valid", {7'd0, sout_valid}, 8'd0);

    // 2. Basic word A5
    load = 1'b1;
    din  = 8'hA5;
    tick();
    load = 1'b0;
    din  = 8'h00;
    check_bits("basic", 8'hA5);
    check_done_cycle("basic");
    tick();
    chk("basic_done_low", {7'd0, done}, 8'd0);
    chk("basic_idle_valid", {7'd0, sout_valid}, 8'd0);

    // 3. Backpressure on bit cycles 3..5
    load = 1'b1;
    din  = 8'hC3;
    tick();
    load = 1'b0;
    got  = 8'h00;
    idx  = 7;
    for (int k = 1; k <= 11; k++) begin
      sr         = !(k >= 3 && k <= 5);
      sout_ready = sr;
      chk("bp_valid", {7'd0, sout_valid}, 8'd1);
      chk("bp_sout", {7'd0, sout}, {7'd0, idx == 7 || idx == 6 || idx <= 1});
      chk("bp_done_early", {7'd0, done}, 8'd0);
      if (sr) begin
        got = {got[6:0], sout};
        idx--;
      end
      tick();
    end
    sout_ready = 1'b1;
    chk("bp_stream", got, 8'hC3);
    check_done_cycle("bp");
    tick();

    // 4. Load during SHIFT is ignored
    load = 1'b1;
    din  = 8'h00;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      load = (k == 4);
      din  = (k == 4) ? 8'hFF : 8'h00;
      chk("ign_sout", {7'd0, sout}, 8'd0);
      chk("ign_ldrdy", {7'd0, ld_ready}, 8'd0);
      tick();
    end
    load = 1'b0;
    check_done_cycle("ign");
    tick();
    chk("ign_no_second", {7'd0, sout_valid}, 8'd0);

    // 5. Reset mid-word, then a fresh word
    load = 1'b1;
    din  = 8'hF0;
    tick();
    load = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      chk("abort_sout", {7'd0, sout}, 8'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", {7'd0, sout_valid}, 8'd0);
    chk("abort_ldrdy", {7'd0, ld_ready}, 8'd1);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_sout0", {7'd0, sout}, 8'd0);
    tick();
    chk("abort_no_done", {7'd0, done}, 8'd0);
    load = 1'b1;
    din  = 8'h81;
    tick();
    load = 1'b0;
    check_bits("after_abort", 8'h81);
    check_done_cycle("after_abort");
    tick();

    // 6. Back-to-back words with load held high
    load = 1'b1;
    din  = 8'h01;
    tick();
    check_bits("b2b_w1", 8'h01);
    check_done_cycle("b2b_w1");
    din = 8'h80;
    tick();
    load = 1'b0;
    din  = 8'h00;
    check_bits("b2b_w2", 8'h80);
    check_done_cycle("b2b_w2");
    tick();
    chk("b2b_end_done", {7'd0, done}, 8'd0);
    chk("b2b_end_valid", {7'd0, sout_valid}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_shift_reader.md
Name: piso_shift_reader

Overview:
Read-side counterpart to the team's load-enabled storage cells. Captures a WIDTH-bit word in parallel, then reads it out serially, MSB first, one bit per accepted beat.
Uses a valid/ready handshake on the serial side and a load/ld_ready handshake on the parallel side. Sits between register banks built from storage cells and any bit-serial consumer.

Parameters:
WIDTH, 8, word width in bits; legal range WIDTH >= 2
CW, $clog2(WIDTH), bit-counter width (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
load  input  1  request to capture din; honoured only while ld_ready=1
din  input  WIDTH  parallel word to serialize
ld_ready  output  1  block is idle and will accept load
sout  output  1  current serial bit (MSB of shift register)
sout_valid  output  1  sout holds a bit of an active word
sout_ready  input  1  consumer accepts sout this cycle
done  output  1  one-cycle pulse after last bit accepted

Behaviour:
- Reset (rst=1 at a clock edge) takes effect at that edge, regardless of any other input. After reset:
  - state=IDLE, shreg=0, cnt=0
  - sout=0, sout_valid=0, ld_ready=1, done=0
- Outputs are decoded from registers only; there is no combinational path from any input to any output.
- IDLE:
  - ld_ready=1, sout_valid=0, sout=0.
  - On an edge with load=1: shreg<=din, cnt<=WIDTH-1, state<=SHIFT.
- SHIFT:
  - ld_ready=0, sout_valid=1, sout=shreg[WIDTH-1].
  - On an edge with sout_ready=1 and cnt!=0: shreg<=shreg<<1 (zero fill), cnt<=cnt-1.
  - On an edge with sout_ready=1 and cnt==0: state<=IDLE, done<=1 for exactly one cycle.
  - On an edge with sout_ready=0: shreg, cnt and sout hold. Stall length is unbounded.
- done is registered and is high during the first IDLE cycle after the last bit. ld_ready is also 1 in that cycle, so a load there is accepted.
- Latency:
  - First bit (MSB) is valid the cycle after the load edge.
  - Minimum word period with sout_ready tied high is WIDTH+1 cycles: WIDTH bit cycles plus one IDLE cycle.
- Boundary conditions:
  - load while in SHIFT (including the final-bit cycle) is ignored; din is not sampled.
  - load and rst at the same edge: reset wins, word is not captured.
  - rst mid-SHIFT aborts the word; no done pulse; the remaining bits are discarded.
  - cnt never underflows; it is only decremented when nonzero.
  - sout_ready is ignored in IDLE.
  - din is sampled only at the accepting edge; later din changes have no effect.

Decomposition:
- Shared package piso_pkg:
  - state enum {IDLE, SHIFT}
  - count-width helper function
  - MSB_FIRST=1 constant, for future LSB-first variants
- One sub-module is natural: shift_stage, one bit of shreg. It is a 2:1 mux (load ? din_bit : lower neighbour) feeding a flop with enable and sync reset.
  - The top instantiates WIDTH shift_stage cells via generate, plus the FSM and counter.

Test Plan (WIDTH=8):
1. Reset: rst=1 for 2 edges, other inputs random -> sout_valid=0, ld_ready=1, sout=0, done=0 on the cycle after the first reset edge.
2. Basic: load=1 with din=8'hA5 for one edge, sout_ready=1 throughout -> sout=1,0,1,0,0,1,0,1 on cycles 1-8 after load; done=1 on cycle 9 with ld_ready=1; done=0 on cycle 10.
3. Backpressure: load din=8'hC3; sout_ready=0 on the 3rd-5th bit cycles -> sout holds 0 during the stall; accepted sequence is still 1,1,0,0,0,0,1,1; done 3 cycles later than unstalled.
4. Ignored load: load 8'h00, then pulse load with din=8'hFF on bit cycle 4 -> all 8 bits read 0; no second word starts; ld_ready stays 0 until the done cycle.
5. Reset mid-word: load 8'hF0; after 3 accepted bits assert rst for 1 edge -> next cycle IDLE, sout_valid=0, no done. Then load 8'h81 -> 1,0,0,0,0,0,0,1.
6. Back-to-back: load held high with din=8'h01, then din=8'h80 from the done cycle -> second word captured in the done cycle; bit stream 0000000 1 then 1 0000000 with exactly one idle cycle between words.
